cpu_sprite_draw: RTL and testbench



---
 rtl/cpu_sprite_draw_if.sv | 30 +++
 rtl/cpu_sprite_draw.sv | 207 ++++++++++++++++++++
 tb/tb_cpu_sprite_draw.sv | 216 +++++++++++++++++++++
 3 files changed

// File: rtl/cpu_sprite_draw_if.sv
// Signal bundle between the CPU decode stage, CPU memory port A, the framebuffer RAM
// and the DXYN sprite drawer. The slave modport is the drawer's view.
interface cpu_sprite_draw_if;
    logic        start;
    logic [5:0]  x;
    logic [4:0]  y;
    logic [3:0]  n;
    logic [11:0] i_addr;
    logic        busy;
    logic        done;
    logic        collision;
    logic        mem_en;
    logic [11:0] mem_addr;
    logic [7:0]  mem_data;
    logic        fb_en;
    logic        fb_we;
    logic [7:0]  fb_addr;
    logic [7:0]  fb_wdata;
    logic [7:0]  fb_rdata;

    modport slave (
        input  start, x, y, n, i_addr, mem_data, fb_rdata,
        output busy, done, collision, mem_en, mem_addr, fb_en, fb_we, fb_addr, fb_wdata
    );

    modport master (
        output start, x, y, n, i_addr, mem_data, fb_rdata,
        input  busy, done, collision, mem_en, mem_addr, fb_en, fb_we, fb_addr, fb_wdata
    );
endinterface

// File: rtl/cpu_sprite_draw.sv
// CHIP-8 DXYN sprite draw engine: fetches N sprite bytes from CPU memory and XORs them into
// the 64x32 framebuffer with collision reporting. Define SPRITE_WRAP_EN for wrap-around drawing.
module cpu_sprite_draw (
    input  logic                   clk,
    input  logic                   reset,
    cpu_sprite_draw_if.slave       io_bus
);

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_FETCH = 3'd1,
        ST_RD0   = 3'd2,
        ST_WR0   = 3'd3,
        ST_RD1   = 3'd4,
        ST_WR1   = 3'd5,
        ST_DONE  = 3'd6
    } state_t;

    state_t      r_state;
    state_t      w_state_next;

    logic [5:0]  r_x;
    logic [4:0]  r_y;
    logic [3:0]  r_n;
    logic [11:0] r_base;
    logic [3:0]  r_row;
    logic [7:0]  r_sprite;
    logic        r_busy;
    logic        r_done;
    logic        r_collision;

    logic [4:0]  w_pix_row;
    logic [5:0]  w_row_sum;
    logic [2:0]  w_byte0;
    logic [2:0]  w_byte1;
    logic [15:0] w_pair;
    logic [7:0]  w_left;
    logic [7:0]  w_right;
    logic        w_second;
    logic        w_last_row;
    logic        w_row_oob;
    logic        w_row_adv;
    logic        w_hit;

    logic        w_mem_en;
    logic [11:0] w_mem_addr;
    logic        w_fb_en;
    logic        w_fb_we;
    logic [7:0]  w_fb_addr;
    logic [7:0]  w_fb_wdata;

    // The sprite byte shifted right by the pixel offset: the upper half lands in the
    // first framebuffer byte, the lower half spills into the next one.
    function automatic logic [15:0] f_align(input logic [7:0] sprite, input logic [2:0] shift);
        logic [15:0] v;
        v = {sprite, 8'h00} >> shift;
        return v;
    endfunction

    assign w_pix_row  = r_y + {1'b0, r_row};
    assign w_row_sum  = {1'b0, r_y} + {2'b00, r_row} + 6'd1;
    assign w_byte0    = r_x[5:3];
    assign w_byte1    = r_x[5:3] + 3'd1;
    assign w_pair     = f_align(r_sprite, r_x[2:0]);
    assign w_left     = w_pair[15:8];
    assign w_right    = w_pair[7:0];
    assign w_last_row = (({1'b0, r_row} + 5'd1) == {1'b0, r_n});

`ifdef SPRITE_WRAP_EN
    assign w_second  = (r_x[2:0] != 3'd0);
    assign w_row_oob = 1'b0;
`else
    assign w_second  = (r_x[2:0] != 3'd0) && (r_x[5:3] != 3'd7);
    assign w_row_oob = (w_row_sum > 6'd31);
`endif

    // Next-state selection and bus decode from the current state.
    always_comb begin
        w_state_next = r_state;
        w_row_adv    = 1'b0;
        w_hit        = 1'b0;
        w_mem_en     = 1'b0;
        w_mem_addr   = 12'h000;
        w_fb_en      = 1'b0;
        w_fb_we      = 1'b0;
        w_fb_addr    = 8'h00;
        w_fb_wdata   = 8'h00;
        case (r_state)
            ST_IDLE: begin
                if (io_bus.start) begin
                    if (io_bus.n == 4'd0) begin
                        w_state_next = ST_DONE;
                    end else begin
                        w_state_next = ST_FETCH;
                    end
                end else begin
                    w_state_next = ST_IDLE;
                end
            end
            ST_FETCH: begin
                w_mem_en     = 1'b1;
                w_mem_addr   = r_base + {8'h00, r_row};
                w_state_next = ST_RD0;
            end
            ST_RD0: begin
                w_fb_en      = 1'b1;
                w_fb_addr    = {w_pix_row, w_byte0};
                w_state_next = ST_WR0;
            end
            ST_WR0: begin
                w_fb_en    = 1'b1;
                w_fb_we    = 1'b1;
                w_fb_addr  = {w_pix_row, w_byte0};
                w_fb_wdata = io_bus.fb_rdata ^ w_left;
                w_hit      = |(io_bus.fb_rdata & w_left);
                if (w_second) begin
                    w_state_next = ST_RD1;
                end else begin
                    w_row_adv    = 1'b1;
                    w_state_next = (w_last_row || w_row_oob) ? ST_DONE : ST_FETCH;
                end
            end
            ST_RD1: begin
                w_fb_en      = 1'b1;
                w_fb_addr    = {w_pix_row, w_byte1};
                w_state_next = ST_WR1;
            end
            ST_WR1: begin
                w_fb_en      = 1'b1;
                w_fb_we      = 1'b1;
                w_fb_addr    = {w_pix_row, w_byte1};
                w_fb_wdata   = io_bus.fb_rdata ^ w_right;
                w_hit        = |(io_bus.fb_rdata & w_right);
                w_row_adv    = 1'b1;
                w_state_next = (w_last_row || w_row_oob) ? ST_DONE : ST_FETCH;
            end
            ST_DONE: begin
                w_state_next = ST_IDLE;
            end
            default: begin
                w_state_next = ST_IDLE;
            end
        endcase
    end

    // State register.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Draw context, sprite byte, collision accumulator and status flags.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_x         <= 6'd0;
            r_y         <= 5'd0;
            r_n         <= 4'd0;
            r_base      <= 12'h000;
            r_row       <= 4'd0;
            r_sprite    <= 8'h00;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
            r_collision <= 1'b0;
        end else begin
            r_busy <= (w_state_next != ST_IDLE) && (w_state_next != ST_DONE);
            r_done <= (w_state_next == ST_DONE);
            case (r_state)
                ST_IDLE: begin
                    if (io_bus.start) begin
                        r_x         <= io_bus.x;
                        r_y         <= io_bus.y;
                        r_n         <= io_bus.n;
                        r_base      <= io_bus.i_addr;
                        r_row       <= 4'd0;
                        r_collision <= 1'b0;
                    end
                end
                ST_RD0: begin
                    r_sprite <= io_bus.mem_data;
                end
                ST_WR0, ST_WR1: begin
                    r_collision <= r_collision | w_hit;
                    if (w_row_adv) begin
                        r_row <= r_row + 4'd1;
                    end
                end
                default: begin
                    r_row <= r_row;
                end
            endcase
        end
    end

    assign io_bus.busy      = r_busy;
    assign io_bus.done      = r_done;
    assign io_bus.collision = r_collision;
    assign io_bus.mem_en    = w_mem_en;
    assign io_bus.mem_addr  = w_mem_addr;
    assign io_bus.fb_en     = w_fb_en;
    assign io_bus.fb_we     = w_fb_we;
    assign io_bus.fb_addr   = w_fb_addr;
    assign io_bus.fb_wdata  = w_fb_wdata;

endmodule

// File: tb/tb_cpu_sprite_draw.sv
// Self-checking bench for cpu_sprite_draw: directed test-plan draws plus random draws,
// checked against a pixel-level model of DXYN.
module tb_cpu_sprite_draw;

    logic clk = 1'b0;
    logic reset;

    cpu_sprite_draw_if bus();

    cpu_sprite_draw dut (
        .clk    (clk),
        .reset  (reset),
        .io_bus (bus)
    );

    always #5 clk = ~clk;

    logic [7:0] mem [4096];
    logic [7:0] fbram [256] = '{default: 8'h00};
    bit         pix [32][64];

    int   mem_cnt   = 0;
    int   fb_cnt    = 0;
    int   proto_err = 0;
    int   done_cnt  = 0;
    logic prev_rd   = 1'b0;
    logic [7:0] prev_addr = 8'h00;

    int n_pass  = 0;
    int n_total = 0;
    int n_fail  = 0;

    // CPU memory and framebuffer RAMs with one-cycle registered reads, plus access monitor.
    always @(posedge clk) begin
        if (bus.mem_en) begin
            bus.mem_data <= mem[bus.mem_addr];
            mem_cnt      <= mem_cnt + 1;
        end
        if (bus.fb_en) begin
            fb_cnt <= fb_cnt + 1;
            if (bus.fb_we) begin
                fbram[bus.fb_addr] <= bus.fb_wdata;
                if (!(prev_rd && (prev_addr == bus.fb_addr)))
                    proto_err <= proto_err + 1;
            end else begin
                bus.fb_rdata <= fbram[bus.fb_addr];
            end
        end
        prev_rd   <= bus.fb_en && !bus.fb_we;
        prev_addr <= bus.fb_addr;
        if (bus.done)
            done_cnt <= done_cnt + 1;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total = n_total + 1;
        assert (obs === exp) n_pass = n_pass + 1;
        else begin
            n_fail = n_fail + 1;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Pixel-level DXYN: XOR sprite bits into the picture, report collision and costs.
    task automatic model_draw(input int dx, input int dy, input int dn, input int da,
                              output bit coll, output int rows, output int cyc, output int acc);
        int row;
        int col;
        bit two;
        logic [7:0] sb;
        coll = 1'b0;
        rows = 0;
        for (int r = 0; r < dn; r++) begin
            row = dy + r;
`ifdef SPRITE_WRAP_EN
            row = row % 32;
`else
            if (row > 31) break;
`endif
            rows++;
            sb = mem[(da + r) % 4096];
            for (int k = 0; k < 8; k++) begin
                col = dx + k;
`ifdef SPRITE_WRAP_EN
                col = col % 64;
`else
                if (col > 63) continue;
`endif
                if (sb[7-k]) begin
                    if (pix[row][col]) coll = 1'b1;
                    pix[row][col] = ~pix[row][col];
                end
            end
        end
`ifdef SPRITE_WRAP_EN
        two = (dx % 8) != 0;
`else
        two = ((dx % 8) != 0) && (dx < 56);
`endif
        cyc = 1 + rows * (two ? 5 : 3);
        acc = rows * (two ? 4 : 2);
    endtask

    function automatic int fb_mismatches();
        int m;
        logic [7:0] e;
        m = 0;
        for (int row = 0; row < 32; row++) begin
            for (int b = 0; b < 8; b++) begin
                for (int k = 0; k < 8; k++) e[7-k] = pix[row][b*8+k];
                if (fbram[row*8+b] !== e) m++;
            end
        end
        return m;
    endfunction

    task automatic draw(input string tag, input logic [5:0] dx, input logic [4:0] dy,
                        input logic [3:0] dn, input logic [11:0] da);
        bit exp_coll;
        int rows, exp_cyc, exp_acc, cyc, m0, f0, p0;
        bit busy_ok;
        model_draw(int'(dx), int'(dy), int'(dn), int'(da), exp_coll, rows, exp_cyc, exp_acc);
        m0 = mem_cnt;
        f0 = fb_cnt;
        p0 = proto_err;
        @(posedge clk); #1;
        bus.start = 1'b1; bus.x = dx; bus.y = dy; bus.n = dn; bus.i_addr = da;
        @(posedge clk); #1;
        bus.start = 1'b0;
        cyc = 1;
        busy_ok = 1'b1;
        while (!bus.done && cyc < 300) begin
            if (!bus.busy) busy_ok = 1'b0;
            @(posedge clk); #1;
            cyc++;
        end
        check({tag, " done_cycle"}, cyc, exp_cyc);
        check({tag, " busy_during"}, busy_ok, 1'b1);
        check({tag, " busy_at_done"}, bus.busy, 1'b0);
        check({tag, " collision"}, bus.collision, exp_coll);
        @(posedge clk); #1;
        check({tag, " done_pulse"}, bus.done, 1'b0);
        check({tag, " collision_held"}, bus.collision, exp_coll);
        check({tag, " mem_reads"}, mem_cnt - m0, rows);
        check({tag, " fb_accesses"}, fb_cnt - f0, exp_acc);
        check({tag, " rd_wr_pairing"}, proto_err - p0, 0);
        check({tag, " fb_contents"}, fb_mismatches(), 0);
    endtask

    initial begin
        bit dc;
        int dr, dcy, dac, d0;
        reset = 1'b1;
        bus.start = 1'b0; bus.x = 6'd0; bus.y = 5'd0; bus.n = 4'd0; bus.i_addr = 12'h000;
        for (int a = 0; a < 4096; a++) mem[a] = 8'($urandom_range(0, 255));
        mem[0] = 8'hF0; mem[1] = 8'h90; mem[2] = 8'h90; mem[3] = 8'h90; mem[4] = 8'hF0;
        mem[12'h010] = 8'hFF;
        mem[12'h020] = 8'hF0;

        repeat (3) @(posedge clk);
        #1;
        check("reset busy", bus.busy, 1'b0);
        check("reset done", bus.done, 1'b0);
        check("reset collision", bus.collision, 1'b0);
        check("reset enables", {bus.mem_en, bus.fb_en, bus.fb_we}, 3'b000);
        check("reset addr_data", {bus.mem_addr, bus.fb_addr, bus.fb_wdata}, 28'h0);
        reset = 1'b0;

        draw("font", 6'd0, 5'd0, 4'd5, 12'h000);
        check("font row4", fbram[8'h20], 8'hF0);
        draw("font_again", 6'd0, 5'd0, 4'd5, 12'h000);
        draw("unaligned", 6'd10, 5'd3, 4'd1, 12'h010);
        check("unaligned fb19", fbram[8'h19], 8'h3F);
        check("unaligned fb1a", fbram[8'h1A], 8'hC0);
        draw("right_edge", 6'd62, 5'd0, 4'd1, 12'h020);
        check("right_edge fb07", fbram[8'h07], 8'h03);
        draw("bottom_edge", 6'd0, 5'd30, 4'd5, 12'h030);
        draw("n_zero", 6'd5, 5'd5, 4'd0, 12'h100);
        draw("addr_wrap", 6'd20, 5'd12, 4'd3, 12'hFFE);

        // Reset in WR0 of row 2 of a font draw that collides with the glyph already there.
        draw("font_setup", 6'd0, 5'd0, 4'd5, 12'h000);
        @(posedge clk); #1;
        bus.start = 1'b1; bus.x = 6'd0; bus.y = 5'd0; bus.n = 4'd4; bus.i_addr = 12'h000;
        @(posedge clk); #1;
        bus.start = 1'b0;
        repeat (8) @(posedge clk);
        #1;
        check("rst_mid wr0_strobe", bus.fb_we, 1'b1);
        check("rst_mid wr0_addr", bus.fb_addr, 8'h10);
        check("rst_mid collision_before", bus.collision, 1'b1);
        reset = 1'b1;
        d0 = done_cnt;
        @(posedge clk); #1;
        reset = 1'b0;
        check("rst_mid busy", bus.busy, 1'b0);
        check("rst_mid done", bus.done, 1'b0);
        check("rst_mid collision", bus.collision, 1'b0);
        check("rst_mid enables", {bus.mem_en, bus.fb_en}, 2'b00);
        repeat (3) @(posedge clk);
        #1;
        check("rst_mid no_done", done_cnt - d0, 0);
        model_draw(0, 0, 3, 0, dc, dr, dcy, dac);
        check("rst_mid fb_contents", fb_mismatches(), 0);
        draw("after_reset", 6'd9, 5'd20, 4'd2, 12'h000);

        for (int t = 0; t < 25; t++) begin
            draw("random", 6'($urandom_range(0, 63)), 5'($urandom_range(0, 31)),
                 4'($urandom_range(0, 15)), 12'($urandom_range(0, 4095)));
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
